// File: rtl/uart_tx.sv
// uart_tx: memory-mapped 8N1 UART transmitter with a small byte FIFO.
// TXDATA at word 0 queues a byte; STATUS at word 1 reports busy/full/overflow/occupancy.
module uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  logic        store_enable,
    input  logic        load_enable,
    input  logic [1:0]  address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        uart_rxd_out,
    output logic        tx_busy
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state, state_next;
    logic [BAUD_W-1:0]  baud_cnt, baud_next;
    logic [2:0]         bit_idx, bit_next;
    logic [7:0]         shift, shift_next;

    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count, count_next;
    logic               overflow;

    logic               fifo_empty, fifo_full;
    logic               push_req, push, pop, ovf_set, status_rd, read_en;
    logic               rxd_next, busy_next;
    logic [31:0]        status_word, read_word;

    // Upper store-data bits carry no meaning for TXDATA.
    logic               unused_data;
    assign unused_data = ^data_in[31:8];

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_C);

    // Bus decode: a push to a full FIFO still lands if the transmitter frees a slot on the same edge.
    always_comb begin
        push_req  = sel && store_enable && (address == 2'd0);
        push      = push_req && (!fifo_full || pop);
        ovf_set   = push_req && fifo_full && !pop;
        read_en   = sel && load_enable && !store_enable;
        status_rd = read_en && (address == 2'd1);
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Transmit FSM next-state logic: baud timing, bit sequencing and FIFO pops.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt + 1'b1;
        bit_next   = bit_idx;
        shift_next = shift;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                baud_next = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_mem[rd_ptr];
                    state_next = START;
                end
            end
            START: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_next  = '0;
                    bit_next   = 3'd0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_next  = '0;
                    shift_next = shift >> 1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_idx + 1'b1;
                    end
                end
            end
            STOP: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_next = '0;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_mem[rd_ptr];
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output values are derived from the upcoming state so the registered line changes on the same edge as the FSM.
    always_comb begin
        case (state_next)
            START:   rxd_next = 1'b0;
            DATA:    rxd_next = shift_next[0];
            default: rxd_next = 1'b1;
        endcase
        busy_next = (state_next != IDLE) || (count_next != '0);
    end

    // Read mux: only STATUS carries information, every other offset reads zero.
    always_comb begin
        status_word      = '0;
        status_word[0]   = tx_busy;
        status_word[1]   = fifo_full;
        status_word[2]   = overflow;
        status_word[8:4] = 5'(count);
        read_word        = '0;
        if (address == 2'd1) begin
            read_word = status_word;
        end
    end

    // FSM, shift register and registered serial line; reset forces the line idle at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            baud_cnt     <= '0;
            bit_idx      <= 3'd0;
            shift        <= 8'd0;
            uart_rxd_out <= 1'b1;
            tx_busy      <= 1'b0;
        end else begin
            state        <= state_next;
            baud_cnt     <= baud_next;
            bit_idx      <= bit_next;
            shift        <= shift_next;
            uart_rxd_out <= rxd_next;
            tx_busy      <= busy_next;
        end
    end

    // FIFO pointers and occupancy; reset discards anything queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    // FIFO storage needs no reset since occupancy guards every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= data_in[7:0];
        end
    end

    // Registered read data and sticky overflow; a new overflow beats a clearing STATUS read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= 32'd0;
            overflow <= 1'b0;
        end else begin
            if (read_en) data_out <= read_word;
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (status_rd) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed and randomized checks of uart_tx against a line decoder and frame model.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        store_enable = 1'b0;
    logic        load_enable = 1'b0;
    logic [1:0]  address = 2'd0;
    logic [31:0] data_in = 32'd0;
    logic [31:0] data_out;
    logic        uart_rxd_out;
    logic        tx_busy;

    int checks = 0;
    int passed = 0;
    int failed = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    logic [7:0] decoded[$];
    int         starts[$];
    int         frame_errs = 0;
    int         dcnt = 0;
    logic       dprev = 1'b1;
    logic [7:0] dbyte = 8'd0;

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sel(sel),
        .store_enable(store_enable),
        .load_enable(load_enable),
        .address(address),
        .data_in(data_in),
        .data_out(data_out),
        .uart_rxd_out(uart_rxd_out),
        .tx_busy(tx_busy)
    );

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line decoder: finds start edges and samples every bit in the middle of its slot.
    always @(negedge clk) begin
        if (!rst_n) begin
            dcnt  = 0;
            dprev = 1'b1;
        end else begin
            if (dcnt == 0) begin
                if (dprev && !uart_rxd_out) begin
                    dcnt = 1;
                    starts.push_back(cyc);
                end
            end else begin
                dcnt++;
                if (dcnt == 2 && uart_rxd_out) frame_errs++;
                if (dcnt >= 6 && dcnt <= 34 && ((dcnt - 6) % 4) == 0)
                    dbyte[(dcnt - 6) / 4] = uart_rxd_out;
                if (dcnt == 38) begin
                    if (!uart_rxd_out) frame_errs++;
                    decoded.push_back(dbyte);
                    dcnt = 0;
                end
            end
            dprev = uart_rxd_out;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected line level k cycles after the edge that popped byte b.
    function automatic logic expectedLine(input logic [7:0] b, input int k);
        int slot;
        slot = (k - 1) / CPB;
        if (slot == 0) return 1'b0;
        else if (slot <= 8) return b[slot - 1];
        else return 1'b1;
    endfunction

    function automatic logic [31:0] statusWord(input int busy, input int full, input int ovf, input int occ);
        return 32'(busy) | (32'(full) << 1) | (32'(ovf) << 2) | (32'(occ) << 4);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic st, input logic ld, input logic [1:0] a, input logic [31:0] d);
        sel = s; store_enable = st; load_enable = ld; address = a; data_in = d;
        tick();
        sel = 1'b0; store_enable = 1'b0; load_enable = 1'b0; address = 2'd0; data_in = 32'd0;
    endtask

    task automatic writeByte(input logic [7:0] b);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, {24'd0, b});
    endtask

    task automatic readReg(input logic [1:0] a);
        applyStimulus(1'b1, 1'b0, 1'b1, a, 32'd0);
    endtask

    task automatic waitDrain(input string tag, input int budget);
        int n;
        n = 0;
        while (tx_busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        checkOutput(tag, (n < budget) ? 32'd1 : 32'd0, 32'd1);
        repeat (3) tick();
    endtask

    task automatic checkDecoded(input string tag);
        checkOutput({tag, "_count"}, decoded.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < decoded.size(); i++)
            checkOutput($sformatf("%s_byte%0d", tag, i), {24'd0, decoded[i]}, {24'd0, exp_q[i]});
        decoded.delete();
        exp_q.delete();
    endtask

    task automatic checkNoGaps(input string tag);
        checkOutput({tag, "_starts"}, starts.size(), exp_q.size());
        for (int i = 1; i < starts.size(); i++)
            checkOutput($sformatf("%s_gap%0d", tag, i), starts[i] - starts[i-1], 10 * CPB);
        starts.delete();
    endtask

    initial begin
        int n;
        int lows;
        logic [7:0] b;

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        checkOutput("reset_line", uart_rxd_out, 1'b1);
        checkOutput("reset_data_out", data_out, 32'd0);
        checkOutput("reset_busy", tx_busy, 1'b0);
        rst_n = 1'b1;
        repeat (2) tick();
        readReg(2'd1);
        checkOutput("reset_status", data_out, 32'd0);

        // Single 0x55 frame, cycle exact
        writeByte(8'h55);
        checkOutput("w55_k0_line", uart_rxd_out, 1'b1);
        checkOutput("w55_k0_busy", tx_busy, 1'b1);
        for (int k = 1; k <= 41; k++) begin
            tick();
            if (k <= 10 * CPB) begin
                checkOutput($sformatf("w55_line_k%0d", k), uart_rxd_out, expectedLine(8'h55, k));
                checkOutput($sformatf("w55_busy_k%0d", k), tx_busy, 1'b1);
            end else begin
                checkOutput("w55_line_end", uart_rxd_out, 1'b1);
                checkOutput("w55_busy_end", tx_busy, 1'b0);
            end
        end
        exp_q.push_back(8'h55);
        starts.delete();
        checkDecoded("w55");

        // Back-to-back 0xA3, 0x0F
        writeByte(8'hA3);
        writeByte(8'h0F);
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h0F);
        waitDrain("b2b_drain", 200);
        checkNoGaps("b2b");
        checkDecoded("b2b");

        // Random burst that never overflows
        n = $urandom_range(3, DEPTH);
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            writeByte(b);
            exp_q.push_back(b);
        end
        waitDrain("rnd_drain", n * 10 * CPB + 50);
        checkNoGaps("rnd");
        checkDecoded("rnd");

        // Overflow: ten writes, first popped, eight queued, tenth dropped
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            writeByte(b);
            if (i < DEPTH + 1) exp_q.push_back(b);
        end
        readReg(2'd1);
        checkOutput("ovf_status", data_out, statusWord(1, 1, 1, DEPTH));
        readReg(2'd1);
        checkOutput("ovf_cleared", data_out, statusWord(1, 1, 0, DEPTH));
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 32'h000000EE);
        checkOutput("ovf_ld_st_ignored_read", data_out, statusWord(1, 1, 0, DEPTH));
        readReg(2'd1);
        checkOutput("ovf_set_again", data_out, statusWord(1, 1, 1, DEPTH));
        waitDrain("ovf_drain", (DEPTH + 1) * 10 * CPB + 50);
        starts.delete();
        checkDecoded("ovf");
        readReg(2'd1);
        checkOutput("ovf_idle_status", data_out, statusWord(0, 0, 0, 0));

        // Reserved offsets
        writeByte(8'h3C);
        exp_q.push_back(8'h3C);
        readReg(2'd1);
        checkOutput("rsv_status1", data_out, statusWord(1, 0, 0, 1));
        readReg(2'd0);
        checkOutput("rsv_read0", data_out, 32'd0);
        readReg(2'd1);
        checkOutput("rsv_status2", data_out, statusWord(1, 0, 0, 0));
        readReg(2'd2);
        checkOutput("rsv_read2", data_out, 32'd0);
        readReg(2'd1);
        checkOutput("rsv_status3", data_out, statusWord(1, 0, 0, 0));
        readReg(2'd3);
        checkOutput("rsv_read3", data_out, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd2, 32'h000000AB);
        waitDrain("rsv_drain", 200);
        starts.delete();
        checkDecoded("rsv");
        readReg(2'd1);
        checkOutput("rsv_status_idle", data_out, 32'd0);

        // Asynchronous reset in the middle of data bit 3 with three bytes queued
        writeByte(8'h00);
        writeByte(8'h11);
        writeByte(8'h22);
        writeByte(8'h33);
        readReg(2'd1);
        checkOutput("rst_pre_status", data_out, statusWord(1, 0, 0, 3));
        repeat (14) tick();
        checkOutput("rst_pre_line", uart_rxd_out, expectedLine(8'h00, 18));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_line", uart_rxd_out, 1'b1);
        checkOutput("rst_async_data_out", data_out, 32'd0);
        checkOutput("rst_async_busy", tx_busy, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (uart_rxd_out !== 1'b1) lows++;
        end
        checkOutput("rst_no_frame_line", lows, 32'd0);
        checkDecoded("rst");
        readReg(2'd1);
        checkOutput("rst_post_status", data_out, 32'd0);

        checkOutput("frame_errors", frame_errs, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
